// File: rtl/uart_fifo_port_if.sv
// Purpose: CPU-side I/O bus between the Z80 port decode and uart_fifo_port.
// Signals:
//   cs       chip select for ports 0x80/0x81 (IORQ already folded in)
//   rs       register select, 0 = ctrl/status, 1 = data
//   rd_n     I/O read strobe, active low
//   wr_n     I/O write strobe, active low
//   data_in  CPU write data
//   data_out CPU read data (combinational on rs)
//   int_n    level interrupt request, active low
// Modports: master = CPU side, slave = serial port side.
interface uart_fifo_port_if;
    logic       cs;
    logic       rs;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       int_n;

    modport master (output cs, rs, rd_n, wr_n, data_in, input data_out, int_n);
    modport slave  (input cs, rs, rd_n, wr_n, data_in, output data_out, int_n);
endinterface

// File: rtl/uart_fifo_port.sv
// Purpose: Z80 I/O-mapped 8N1 serial port with RX/TX FIFOs and a level interrupt.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    CPU I/O bus (uart_fifo_port_if.slave)
//   rxd    asynchronous serial input, idle high
//   txd    serial output, idle high
// Status read (rs=0): {~int_n, TXBUSY, OVR, FE, 0, RX>=half, TDRE, RDRF}.
// Ctrl write (rs=0): b7 RIE, b5 TIE, b6 clears FE/OVR, b1:0==11 master reset.
module uart_fifo_port #(
    parameter int unsigned c_clk_hz         = 25000000,
    parameter int unsigned c_baud           = 9600,
    parameter int unsigned c_fifo_addr_bits = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_fifo_port_if.slave bus,
    input  logic            rxd,
    output logic            txd
);
    localparam int unsigned c_div   = c_clk_hz / (16 * c_baud);
    localparam int unsigned c_depth = 2 ** c_fifo_addr_bits;
    localparam int unsigned c_aw    = c_fifo_addr_bits;
    localparam int unsigned c_pw    = c_aw + 1;
    localparam int unsigned c_cw    = (c_div > 1) ? $clog2(c_div) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // Oversampling tick: one pulse every c_div clocks, 16 per bit.
    logic [c_cw-1:0] r_baud;
    logic            w_tick;
    assign w_tick = (r_baud == c_cw'(c_div - 1));

    // CPU strobe edge detection.
    logic r_wr_q, r_rd_q;
    logic w_wr_now, w_rd_now, w_wr_pulse, w_rd_end, w_ctrl_wr, w_data_wr, w_mreset;
    assign w_wr_now   = bus.cs & ~bus.wr_n;
    assign w_rd_now   = bus.cs & bus.rs & ~bus.rd_n;
    assign w_wr_pulse = w_wr_now & ~r_wr_q;
    assign w_rd_end   = r_rd_q & ~w_rd_now;  // pop once the data read completes
    assign w_ctrl_wr  = w_wr_pulse & ~bus.rs;
    assign w_data_wr  = w_wr_pulse & bus.rs;
    assign w_mreset   = w_ctrl_wr & (bus.data_in[1:0] == 2'b11);

    // FIFOs: extra pointer bit distinguishes full from empty.
    logic [7:0]    r_rx_mem [c_depth];
    logic [7:0]    r_tx_mem [c_depth];
    logic [c_aw:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [c_aw:0] w_rx_count;
    logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_half;
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_full  = (r_rx_wp[c_aw] != r_rx_rp[c_aw]) &&
                        (r_rx_wp[c_aw-1:0] == r_rx_rp[c_aw-1:0]);
    assign w_tx_full  = (r_tx_wp[c_aw] != r_tx_rp[c_aw]) &&
                        (r_tx_wp[c_aw-1:0] == r_tx_rp[c_aw-1:0]);
    assign w_rx_count = r_rx_wp - r_rx_rp;
    assign w_half     = (w_rx_count >= c_pw'(c_depth / 2));

    // Receiver state.
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_e r_rx_state, w_rx_state_d;
    logic [3:0]  r_rx_tick, w_rx_tick_d;
    logic [2:0]  r_rx_bit, w_rx_bit_d;
    logic [7:0]  r_rx_shift, w_rx_shift_d;
    logic        w_rx_done, w_rx_bad_stop, w_rx_push, w_rx_pop, w_set_ovr;

    // Transmitter state.
    uart_state_e r_tx_state, w_tx_state_d;
    logic [3:0]  r_tx_tick, w_tx_tick_d;
    logic [2:0]  r_tx_bit, w_tx_bit_d;
    logic [7:0]  r_tx_shift, w_tx_shift_d;
    logic        r_txd, w_txd_d, w_tx_pop, w_tx_push, w_tx_busy;

    logic r_rie, r_tie, r_fe, r_ovr, r_int_n;

    assign w_rx_pop  = w_rd_end & ~w_rx_empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same clock.
    assign w_rx_push = w_rx_done & (~w_rx_full | w_rx_pop);
    assign w_set_ovr = w_rx_done & w_rx_full & ~w_rx_pop;
    assign w_tx_push = w_data_wr & (~w_tx_full | w_tx_pop);
    assign w_tx_busy = (r_tx_state != StIdle) | ~w_tx_empty;

    always_comb begin
        w_rx_state_d  = r_rx_state;
        w_rx_tick_d   = r_rx_tick;
        w_rx_bit_d    = r_rx_bit;
        w_rx_shift_d  = r_rx_shift;
        w_rx_done     = 1'b0;
        w_rx_bad_stop = 1'b0;
        case (r_rx_state)
            StIdle: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_d = StStart;
                    w_rx_tick_d  = 4'd0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (r_rx_tick == 4'd7) begin
                        // Mid start bit: a high line here was a glitch.
                        w_rx_tick_d  = 4'd0;
                        w_rx_bit_d   = 3'd0;
                        w_rx_state_d = r_rx_s2 ? StIdle : StData;
                    end else begin
                        w_rx_tick_d = r_rx_tick + 4'd1;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    w_rx_tick_d = r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
                        w_rx_bit_d   = r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) w_rx_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_rx_tick_d = r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        w_rx_state_d  = StIdle;
                        w_rx_done     = r_rx_s2;
                        w_rx_bad_stop = ~r_rx_s2;
                    end
                end
            end
            default: w_rx_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_tick_d  = r_tx_tick;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_txd_d      = r_txd;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            StIdle: begin
                w_txd_d = 1'b1;
                if (w_tick && !w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_shift_d = r_tx_mem[r_tx_rp[c_aw-1:0]];
                    w_txd_d      = 1'b0;
                    w_tx_tick_d  = 4'd0;
                    w_tx_state_d = StStart;
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_tx_tick_d = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) begin
                        w_tx_state_d = StData;
                        w_tx_bit_d   = 3'd0;
                        w_txd_d      = r_tx_shift[0];
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    w_tx_tick_d = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) begin
                        if (r_tx_bit == 3'd7) begin
                            w_tx_state_d = StStop;
                            w_txd_d      = 1'b1;
                        end else begin
                            w_tx_bit_d   = r_tx_bit + 3'd1;
                            w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                            w_txd_d      = r_tx_shift[1];
                        end
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_tx_tick_d = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) w_tx_state_d = StIdle;
                end
            end
            default: w_tx_state_d = StIdle;
        endcase
        if (w_mreset) begin
            w_tx_state_d = StIdle;
            w_tx_tick_d  = 4'd0;
            w_txd_d      = 1'b1;
            w_tx_pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud     <= '0;
            r_wr_q     <= 1'b0;
            r_rd_q     <= 1'b0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= StIdle;
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_state <= StIdle;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_rie      <= 1'b0;
            r_tie      <= 1'b0;
            r_fe       <= 1'b0;
            r_ovr      <= 1'b0;
            r_int_n    <= 1'b1;
        end else begin
            r_baud     <= w_tick ? '0 : r_baud + c_cw'(1);
            r_wr_q     <= w_wr_now;
            r_rd_q     <= w_rd_now;
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_d;
            r_rx_tick  <= w_rx_tick_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
            r_tx_state <= w_tx_state_d;
            r_tx_tick  <= w_tx_tick_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_txd      <= w_txd_d;
            if (w_mreset) begin
                r_rx_wp <= '0;
                r_rx_rp <= '0;
                r_tx_wp <= '0;
                r_tx_rp <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + c_pw'(1);
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_pw'(1);
                if (w_tx_push) r_tx_wp <= r_tx_wp + c_pw'(1);
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_pw'(1);
            end
            if (w_mreset || (w_ctrl_wr && bus.data_in[6])) begin
                r_fe  <= 1'b0;
                r_ovr <= 1'b0;
            end else begin
                if (w_rx_bad_stop) r_fe  <= 1'b1;
                if (w_set_ovr)     r_ovr <= 1'b1;
            end
            if (w_ctrl_wr) begin
                r_rie <= bus.data_in[7] & ~w_mreset;
                r_tie <= bus.data_in[5] & ~w_mreset;
            end
            r_int_n <= ~((r_rie & ~w_rx_empty) | (r_tie & ~w_tx_busy));
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[c_aw-1:0]] <= r_rx_shift;
        if (w_tx_push) r_tx_mem[r_tx_wp[c_aw-1:0]] <= bus.data_in;
    end

    assign bus.data_out = bus.rs ? (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[c_aw-1:0]])
                                 : {~r_int_n, w_tx_busy, r_ovr, r_fe, 1'b0, w_half,
                                    ~w_tx_full, ~w_rx_empty};
    assign bus.int_n    = r_int_n;
    assign txd          = r_txd;
endmodule

// File: tb/tb_uart_fifo_port.sv
// Bench for uart_fifo_port: directed steps with random payloads, checked against a
// queue-based model of the RX FIFO, flags and interrupt enables.
module tb_uart_fifo_port;
    localparam int unsigned C_BAUD   = 9600;
    localparam int unsigned C_DIV    = 4;
    localparam int unsigned C_CLK_HZ = 16 * C_BAUD * C_DIV;
    localparam int          C_BIT    = 16 * C_DIV;
    localparam int          C_DEPTH  = 16;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic txd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_model[$];
    bit m_fe, m_ovr, m_rie, m_tie;

    uart_fifo_port_if bus_if ();

    uart_fifo_port #(
        .c_clk_hz        (C_CLK_HZ),
        .c_baud          (C_BAUD),
        .c_fifo_addr_bits(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave),
        .rxd  (rxd),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_status(input bit txbusy, input bit tdre);
        bit rdrf;
        bit irq;
        bit half;
        rdrf = (rx_model.size() != 0);
        half = (rx_model.size() >= C_DEPTH / 2);
        irq  = (m_rie && rdrf) || (m_tie && !txbusy);
        return {irq, txbusy, m_ovr, m_fe, 1'b0, half, tdre, rdrf};
    endfunction

    function automatic void model_clear();
        rx_model.delete();
        m_fe = 0; m_ovr = 0; m_rie = 0; m_tie = 0;
    endfunction

    task automatic cpu_write(input logic sel, input logic [7:0] d);
        bus_if.cs = 1'b1; bus_if.rs = sel; bus_if.data_in = d; bus_if.wr_n = 1'b0;
        step(6);
        bus_if.wr_n = 1'b1; bus_if.cs = 1'b0; bus_if.rs = 1'b0;
        step(2);
        if (!sel) begin
            if (d[1:0] == 2'b11) model_clear();
            else begin
                m_rie = d[7]; m_tie = d[5];
                if (d[6]) begin m_fe = 0; m_ovr = 0; end
            end
        end
    endtask

    task automatic cpu_read(input logic sel, output logic [7:0] d, output bit stable);
        bus_if.cs = 1'b1; bus_if.rs = sel; bus_if.rd_n = 1'b0;
        step(1);
        d = bus_if.data_out;
        stable = 1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus_if.data_out !== d) stable = 0;
        end
        bus_if.rd_n = 1'b1; bus_if.cs = 1'b0; bus_if.rs = 1'b0;
        step(2);
    endtask

    // Check a data read against the model's RX head (0x00 when empty).
    task automatic read_and_check(input string tag);
        logic [7:0] d;
        bit         st;
        logic [7:0] exp;
        exp = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        cpu_read(1'b1, d, st);
        check(tag, d, exp);
        check({tag, " stable"}, st, 1);
    endtask

    // Serialise one 8N1 frame onto rxd; lat = clocks from RDRF rising to int_n falling.
    task automatic send_rx(input logic [7:0] b, input logic stopv, output int lat);
        logic [9:0] fr;
        int t_rdrf;
        int t_int;
        fr = {stopv, b, 1'b0};
        t_rdrf = -1; t_int = -1;
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            for (int c = 0; c < C_BIT; c++) begin
                step(1);
                if (t_rdrf < 0 && bus_if.data_out[0] === 1'b1) t_rdrf = i * C_BIT + c;
                if (t_int < 0 && bus_if.int_n === 1'b0) t_int = i * C_BIT + c;
            end
        end
        rxd = 1'b1;
        lat = (t_rdrf >= 0 && t_int >= 0) ? t_int - t_rdrf : -1;
        if (!stopv) m_fe = 1;
        else if (rx_model.size() >= C_DEPTH) m_ovr = 1;
        else rx_model.push_back(b);
    endtask

    task automatic capture_tx(input int budget, output bit found, output logic [7:0] b,
                              output logic st, output logic sp, output logic busy);
        int waited;
        waited = 0; found = 0; b = 8'h00; st = 1'bx; sp = 1'bx; busy = 1'bx;
        while (txd !== 1'b0 && waited < budget) begin step(1); waited++; end
        if (txd !== 1'b0) return;
        found = 1;
        step(C_BIT / 2);
        st = txd;
        for (int i = 0; i < 8; i++) begin step(C_BIT); b[i] = txd; end
        step(C_BIT);
        sp = txd;
        busy = bus_if.data_out[6];
    endtask

    initial begin
        logic [7:0] d, b;
        logic       st, sp, busy;
        bit         found, stbl;
        int         lat, lows;
        logic [7:0] wr_bytes[18];

        reset = 1'b1; rxd = 1'b1;
        bus_if.cs = 1'b0; bus_if.rs = 1'b0; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
        bus_if.data_in = 8'h00;
        model_clear();
        step(5);
        reset = 1'b0;
        step(2);

        // Reset state
        check("reset status", bus_if.data_out, 8'h02);
        check("reset txd", txd, 1);
        check("reset int_n", bus_if.int_n, 1);

        // TX 0x55: latency to start bit, frame contents, busy until stop ends
        bus_if.cs = 1'b1; bus_if.rs = 1'b1; bus_if.data_in = 8'h55; bus_if.wr_n = 1'b0;
        lat = 0;
        while (txd !== 1'b0 && lat < 4 * C_DIV + 8) begin step(1); lat++; end
        bus_if.wr_n = 1'b1; bus_if.cs = 1'b0; bus_if.rs = 1'b0;
        check("tx start latency", (lat >= 1 && lat <= C_DIV + 1), 1);
        capture_tx(0, found, b, st, sp, busy);
        check("tx55 found", found, 1);
        check("tx55 start", st, 0);
        check("tx55 data", b, 8'h55);
        check("tx55 stop", sp, 1);
        check("tx55 busy in stop", busy, 1);
        step(C_BIT / 2 + C_DIV + 2);
        check("tx idle status", bus_if.data_out, model_status(0, 1));

        // RX 0xA3 then random bytes
        send_rx(8'hA3, 1'b1, lat);
        check("rx A3 status", bus_if.data_out, model_status(0, 1));
        read_and_check("rx A3 read");
        check("rx empty status", bus_if.data_out, model_status(0, 1));
        for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'b1, lat);
        check("rx rand status", bus_if.data_out, model_status(0, 1));
        for (int i = 0; i < 3; i++) read_and_check("rx rand read");

        // Overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) begin
            send_rx(8'(i), 1'b1, lat);
            check("rx fill status", bus_if.data_out, model_status(0, 1));
        end
        for (int i = 0; i < 16; i++) read_and_check("rx drain read");
        read_and_check("rx read when empty");
        cpu_write(1'b0, 8'h40);
        check("ovr cleared", bus_if.data_out, model_status(0, 1));

        // Framing error, then a one-tick glitch
        send_rx(8'($urandom), 1'b0, lat);
        check("fe status", bus_if.data_out, model_status(0, 1));
        cpu_write(1'b0, 8'h40);
        check("fe cleared", bus_if.data_out, model_status(0, 1));
        rxd = 1'b0; step(C_DIV); rxd = 1'b1;
        step(3 * C_BIT);
        check("glitch no byte", bus_if.data_out, model_status(0, 1));

        // RX interrupt
        cpu_write(1'b0, 8'h80);
        check("rie int_n idle", bus_if.int_n, 1);
        send_rx(8'h3C, 1'b1, lat);
        check("rx irq latency", (lat >= 0 && lat <= 2), 1);
        check("rx irq status", bus_if.data_out, model_status(0, 1));
        read_and_check("rx 3C read");
        check("int_n after pop", bus_if.int_n, 1);

        // TX-empty interrupt
        cpu_write(1'b0, 8'h20);
        check("tie int_n", bus_if.int_n, 0);
        check("tie status", bus_if.data_out, model_status(0, 1));
        cpu_write(1'b0, 8'h00);
        check("int off", bus_if.int_n, 1);

        // TX burst: one byte goes in flight, 16 fill the FIFO, the 18th is dropped
        foreach (wr_bytes[i]) wr_bytes[i] = 8'($urandom);
        foreach (wr_bytes[i]) cpu_write(1'b1, wr_bytes[i]);
        check("tx full status", bus_if.data_out, model_status(1, 0));
        step(9 * C_BIT + C_BIT / 2 - 17 * 8 - 6);
        check("tx frame0 stop", txd, 1);
        for (int k = 1; k <= 16; k++) begin
            capture_tx(C_BIT, found, b, st, sp, busy);
            check("tx burst found", found, 1);
            check("tx burst start", st, 0);
            check("tx burst data", b, wr_bytes[k]);
            check("tx burst stop", sp, 1);
        end
        capture_tx(2 * C_BIT, found, b, st, sp, busy);
        check("tx dropped byte absent", found, 0);
        check("tx burst done status", bus_if.data_out, model_status(0, 1));

        // Master reset mid-frame
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h00);
        step(C_BIT);
        check("tx low mid frame", txd, 0);
        bus_if.cs = 1'b1; bus_if.rs = 1'b0; bus_if.data_in = 8'h03; bus_if.wr_n = 1'b0;
        step(1);
        model_clear();
        check("mreset txd", txd, 1);
        check("mreset status", bus_if.data_out, model_status(0, 1));
        bus_if.wr_n = 1'b1; bus_if.cs = 1'b0;
        lows = 0;
        for (int i = 0; i < 3 * C_BIT; i++) begin step(1); if (txd !== 1'b1) lows++; end
        check("mreset no frame", lows, 0);

        // Synchronous reset mid TX and mid RX frame
        cpu_write(1'b1, 8'($urandom));
        step(C_BIT / 2);
        rxd = 1'b0;
        step(3 * C_BIT);
        reset = 1'b1; rxd = 1'b1;
        step(1);
        reset = 1'b0;
        model_clear();
        check("sreset txd", txd, 1);
        check("sreset int_n", bus_if.int_n, 1);
        check("sreset status", bus_if.data_out, model_status(0, 1));
        step(12 * C_BIT);
        check("sreset no partial byte", bus_if.data_out, model_status(0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
